// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
//
// Turns a raw, asynchronous, bouncing push-button level into a clean level
// that is synchronous to i_clock. It also produces one-cycle press/release
// strobes. The raw input goes through a two-flop synchronizer and then a
// four-state debounce FSM. The FSM uses a stability counter: the synchronized
// level must disagree with o_btn on DEBOUNCE_CYCLES consecutive edges before
// o_btn follows it.
//
// Ports
//   i_clock    in   system clock, rising edge
//   i_reset    in   synchronous active-low reset (0 = reset)
//   i_btn_raw  in   asynchronous raw button level
//   o_btn      out  debounced level
//   o_rise     out  one-cycle strobe on o_btn 0->1
//   o_fall     out  one-cycle strobe on o_btn 1->0
//   o_busy     out  high while a transition is being qualified
//
// Parameters
//   DEBOUNCE_CYCLES  qualification length in clock cycles. Legal range is
//                    1 .. 2**20. About 1e6 gives 10 ms at 100 MHz.
//
// Build option
//   BTN_DEBOUNCE_INVERT_EN  when defined, the raw input is inverted ahead of
//                           the synchronizer. This suits active-low buttons,
//                           so that o_btn = 1 means pressed.
//
// State table
//   state        | meaning
//   STABLE_LOW   | o_btn = 0, input agrees with it
//   PEND_HIGH    | o_btn = 0, input has been high for 'cnt' edges
//   STABLE_HIGH  | o_btn = 1, input agrees with it
//   PEND_LOW     | o_btn = 1, input has been low for 'cnt' edges
// ---------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_btn_raw,
    output logic o_btn,
    output logic o_rise,
    output logic o_fall,
    output logic o_busy
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        PEND_HIGH   = 2'b01,
        STABLE_HIGH = 2'b11,
        PEND_LOW    = 2'b10
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             btn_in;
    logic             s1;
    logic             s2;

`ifdef BTN_DEBOUNCE_INVERT_EN
    assign btn_in = ~i_btn_raw;
`else
    assign btn_in = i_btn_raw;
`endif

    // Two-flop synchronizer. Only s2 is allowed to reach the FSM.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_in;
            s2 <= s1;
        end
    end

    // Debounce FSM. All outputs are registered here together with the state.
    // Strobes default low, so each one lasts exactly one cycle.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state  <= STABLE_LOW;
            cnt    <= '0;
            o_btn  <= 1'b0;
            o_rise <= 1'b0;
            o_fall <= 1'b0;
            o_busy <= 1'b0;
        end else begin
            o_rise <= 1'b0;
            o_fall <= 1'b0;
            case (state)
                STABLE_LOW: begin
                    if (s2) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            // A single disagreeing sample already qualifies.
                            state  <= STABLE_HIGH;
                            cnt    <= '0;
                            o_btn  <= 1'b1;
                            o_rise <= 1'b1;
                            o_busy <= 1'b0;
                        end else begin
                            state  <= PEND_HIGH;
                            cnt    <= CNT_ONE;
                            o_busy <= 1'b1;
                        end
                    end else begin
                        cnt <= '0;
                    end
                end

                PEND_HIGH: begin
                    if (!s2) begin
                        // Glitch: drop back and restart qualification later.
                        state  <= STABLE_LOW;
                        cnt    <= '0;
                        o_busy <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state  <= STABLE_HIGH;
                        cnt    <= '0;
                        o_btn  <= 1'b1;
                        o_rise <= 1'b1;
                        o_busy <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                STABLE_HIGH: begin
                    if (!s2) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state  <= STABLE_LOW;
                            cnt    <= '0;
                            o_btn  <= 1'b0;
                            o_fall <= 1'b1;
                            o_busy <= 1'b0;
                        end else begin
                            state  <= PEND_LOW;
                            cnt    <= CNT_ONE;
                            o_busy <= 1'b1;
                        end
                    end else begin
                        cnt <= '0;
                    end
                end

                PEND_LOW: begin
                    if (s2) begin
                        state  <= STABLE_HIGH;
                        cnt    <= '0;
                        o_busy <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state  <= STABLE_LOW;
                        cnt    <= '0;
                        o_btn  <= 1'b0;
                        o_fall <= 1'b1;
                        o_busy <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                default: begin
                    state  <= STABLE_LOW;
                    cnt    <= '0;
                    o_btn  <= 1'b0;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Conditions a raw, asynchronous, bouncing push-button/switch input into a clean, clock-synchronous level. Feeds the i_btn input of the 1010 sequence detector directly.
- Also emits one-cycle rise and fall strobes for downstream logic that needs press/release events.
- Structure: 2-flop synchronizer, then a 4-state debounce FSM with a stability counter.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive clock cycles the synchronized input must differ from o_btn before o_btn changes. Legal range 1..2^20. Small default for simulation; boards override to about 1e6 for 10 ms at 100 MHz.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), counter width. Derived; never overridden.

Ports:
- i_clock, input, 1, system clock, rising-edge.
- i_reset, input, 1, synchronous active-low reset: 0 = reset, sampled on the i_clock rising edge.
- i_btn_raw, input, 1, asynchronous raw button level.
- o_btn, output, 1, debounced level. Connects to the sequence detector's i_btn.
- o_rise, output, 1, one-cycle pulse when o_btn goes 0->1.
- o_fall, output, 1, one-cycle pulse when o_btn goes 1->0.
- o_busy, output, 1, high while a transition is pending (FSM in PEND_HIGH or PEND_LOW).

Behaviour:
- Reset (i_reset==0 at rising edge):
  - Sync flops s1, s2 = 0.
  - Counter = 0; FSM = STABLE_LOW.
  - o_btn = 0, o_rise = 0, o_fall = 0, o_busy = 0.
  - Reset overrides all other activity, including a pending transition. The pending transition is discarded, not completed.
- Synchronizer: s1 <= i_btn_raw; s2 <= s1, every edge. Only s2 feeds the FSM. s1 drives nothing else.
- FSM states, 2-bit encoding: STABLE_LOW (o_btn=0), PEND_HIGH (o_btn=0), STABLE_HIGH (o_btn=1), PEND_LOW (o_btn=1).
- STABLE_LOW:
  - If s2==1: counter <= 1. If DEBOUNCE_CYCLES==1, commit immediately (see commit). Otherwise go to PEND_HIGH.
  - Else stay; counter held at 0.
- PEND_HIGH:
  - If s2==0 (glitch): counter <= 0, go to STABLE_LOW, no pulse.
  - Else if counter==DEBOUNCE_CYCLES-1: commit.
  - Else counter <= counter+1.
- Commit to high: o_btn <= 1, o_rise <= 1 for exactly one cycle, counter <= 0, go to STABLE_HIGH.
- STABLE_HIGH and PEND_LOW: mirror images with polarity inverted. Commit to low sets o_btn <= 0 and o_fall <= 1 for one cycle.
- Latency: raw level stable from before edge E0 (captured into s1 at E0) gives o_btn change and strobe registered at edge E0+DEBOUNCE_CYCLES+1.
- Any return of s2 to the current o_btn value before commit restarts qualification from zero.
- o_rise and o_fall are registered, never both high, and deasserted on the edge after assertion.
- o_busy = 1 exactly in PEND_HIGH/PEND_LOW. Registered with the state.
- Input changing on the same edge as a commit: the commit still happens. The new value starts a fresh qualification from the next edge.
- The counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- All outputs are registered. No combinational path from i_btn_raw to any output.

Optional Feature:
- Macro BTN_DEBOUNCE_INVERT_EN.
- When defined: i_btn_raw is inverted before s1, for active-low board buttons. o_btn=1 then means pressed. After reset, o_btn = 0 until a released (raw=1) level qualifies as 0; no strobe fires from reset state.
- When undefined: no inversion; i_btn_raw feeds s1 directly.

Test Plan (DEBOUNCE_CYCLES=4, 10 ns clock, macro undefined):
1. Hold i_reset=0 for 3 edges with i_btn_raw=1 -> o_btn=0, o_rise=0, o_fall=0, o_busy=0 throughout reset.
2. Release reset; raise i_btn_raw before edge E0 and hold -> o_busy=1 from E2, o_btn=1 and o_rise=1 at E5, o_rise=0 at E6.
3. From o_btn=1, pulse i_btn_raw low for 2 cycles then high -> o_busy pulses high, o_btn stays 1, o_fall never asserts.
4. Drive the 1010 pattern with 20 ns per bit (2 cycles) -> o_btn never changes (filtered). Repeat with 80 ns per bit -> o_btn reproduces 1,0,1,0, delayed by 5 cycles, with alternating o_rise/o_fall strobes.
5. Assert i_reset=0 during PEND_HIGH (counter=2) -> next edge: state STABLE_LOW, o_busy=0, no o_rise. After release with raw still 1, full 5-edge qualification is needed again.
6. Rebuild with BTN_DEBOUNCE_INVERT_EN and hold raw=0 after reset -> o_btn=1 and o_rise=1 at E5.
